// File: rtl/alu_pkg.sv
// alu_pkg
// Shared ALUCtl code constants used by both the ALU control decoder and the
// execution unit, plus a helper that tells whether a code is one of the
// six operations the execution unit implements.
// No ports (package).
package alu_pkg;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_SLT = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;
  localparam logic [3:0] ALU_AND = 4'b0100;
  localparam logic [3:0] ALU_CTZ = 4'b1111;

  // True when ctl names an operation the execution unit implements
  function automatic logic is_legal_ctl(input logic [3:0] ctl);
    logic legal;
    legal = 1'b0;
    case (ctl)
      ALU_ADD, ALU_SUB, ALU_SLT, ALU_OR, ALU_AND, ALU_CTZ: legal = 1'b1;
      default:                                             legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/alu_ctz_scan.sv
// alu_ctz_scan
// Bit-serial trailing-zero scanner for the CTZ operation. On load it takes
// the source shifted right by one with the count primed to 1 (bit 0 has
// already been examined by the caller). While busy it shifts one bit per
// cycle until the low bit is set; found/count then report the position.
// Ports:
//   clk    in   rising-edge clock
//   rst    in   synchronous active-high reset (clears register and count)
//   load   in   capture a new source (src >> 1, count = 1)
//   src    in   XLEN-bit CTZ source operand
//   busy   in   scan in progress; shift while the low bit is still clear
//   found  out  low bit of the scan register is set
//   count  out  current trailing-zero count
module alu_ctz_scan #(
  parameter int XLEN = 32,
  parameter int CW   = $clog2(XLEN + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic [XLEN-1:0] src,
  input  logic            busy,
  output logic            found,
  output logic [CW-1:0]   count
);

  logic [XLEN-1:0] shreg_q, shreg_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  // Next-state for the scan register and counter. A load always wins over
  // a shift; once the low bit is set the pair freezes so count stays put.
  always_comb begin
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    if (load) begin
      shreg_d = src >> 1;
      cnt_d   = CW'(1);
    end else if (busy && !shreg_q[0]) begin
      shreg_d = shreg_q >> 1;
      cnt_d   = cnt_q + CW'(1);
    end
  end

  // Scan state registers, cleared by the synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

  assign found = shreg_q[0];
  assign count = cnt_q;

endmodule

// File: rtl/alu_exec_unit.sv
// alu_exec_unit
// Execution end of the ALUCtl interface. Accepts an ALUCtl code and two
// operands over a valid/ready handshake and returns a registered result.
// ADD/SUB/SLT/OR/AND finish in one cycle; CTZ scans one bit per cycle
// through alu_ctz_scan when operand A has neither all-zero nor bit 0 set.
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset
//   in_valid   in   request valid
//   in_ready   out  unit idle and able to accept
//   alu_ctl    in   4-bit operation code (alu_pkg constants)
//   op_a       in   operand A (CTZ source)
//   op_b       in   operand B (ignored by CTZ)
//   out_valid  out  result valid
//   out_ready  in   consumer accepts result
//   result     out  registered result
//   zero       out  registered result==0
//   illegal    out  registered flag: alu_ctl was not a legal code
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      alu_ctl,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            illegal
);

  localparam int CW = $clog2(XLEN + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            zero_q, zero_d;
  logic            illegal_q, illegal_d;

  logic            scan_load;
  logic            scan_busy;
  logic            scan_found;
  logic [CW-1:0]   scan_count;

  alu_ctz_scan #(
    .XLEN (XLEN),
    .CW   (CW)
  ) u_ctz_scan (
    .clk   (clk),
    .rst   (rst),
    .load  (scan_load),
    .src   (op_a),
    .busy  (scan_busy),
    .found (scan_found),
    .count (scan_count)
  );

  // FSM next-state and output-register next values. Result, zero and
  // illegal only change on the transition into DONE, so they hold steady
  // through SCAN and under backpressure in DONE.
  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    zero_d    = zero_q;
    illegal_d = illegal_q;
    scan_load = 1'b0;
    scan_busy = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          state_d   = ST_DONE;
          illegal_d = !is_legal_ctl(alu_ctl);
          case (alu_ctl)
            ALU_ADD: result_d = op_a + op_b;
            ALU_SUB: result_d = op_a - op_b;
            ALU_SLT: result_d = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            ALU_OR:  result_d = op_a | op_b;
            ALU_AND: result_d = op_a & op_b;
            ALU_CTZ: begin
              // Zero and odd sources resolve immediately; anything else scans
              if (op_a == '0) begin
                result_d = XLEN'(XLEN);
              end else if (op_a[0]) begin
                result_d = '0;
              end else begin
                state_d   = ST_SCAN;
                scan_load = 1'b1;
                result_d  = result_q;
                illegal_d = illegal_q;
              end
            end
            default: result_d = '0;
          endcase
          if (state_d == ST_DONE) begin
            zero_d = (result_d == '0);
          end
        end
      end

      ST_SCAN: begin
        scan_busy = 1'b1;
        if (scan_found) begin
          state_d   = ST_DONE;
          result_d  = XLEN'(scan_count);
          zero_d    = (scan_count == '0);
          illegal_d = 1'b0;
        end
      end

      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; reset abandons any op in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      result_q  <= '0;
      zero_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      result_q  <= result_d;
      zero_q    <= zero_d;
      illegal_q <= illegal_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign result    = result_q;
  assign zero      = zero_q;
  assign illegal   = illegal_q;

endmodule
